// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc: multi-cycle control FSM for the SISC CPU.
// Strobes are registered from the next state, so each one is valid for the whole state it belongs to.
module sisc_ctrl_mc #(
   parameter int OPW          = 4,
   parameter int MEM_WAIT_MAX = 8,
   parameter int IMM_MODE     = 8
) (
   input  logic           clk,
   input  logic           rst_f,
   input  logic [OPW-1:0] opcode,
   input  logic [OPW-1:0] mm,
   input  logic [3:0]     stat,
   input  logic           mem_rdy,
   output logic           ir_load,
   output logic           pc_write,
   output logic           br_sel,
   output logic           pc_sel,
   output logic [1:0]     alu_op,
   output logic           rf_we,
   output logic           wb_sel,
   output logic           mem_rd,
   output logic           mem_wr,
   output logic           halted,
   output logic           mem_err
);
   typedef enum logic [2:0] {START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_e;
   localparam logic [9:0] OUT_IDLE = 10'b0000_11_0000;
   state_e     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic [9:0] out_q, out_d;
   logic       halted_q, mem_err_q, err_d;
   logic       is_lod, is_str, is_alu, is_br, is_abs, taken;
   logic [3:0] mask;
   assign is_lod = opcode == OPW'(1);
   assign is_str = opcode == OPW'(2);
   assign is_alu = opcode == OPW'(8);
   assign is_br  = opcode >= OPW'(4) && opcode <= OPW'(7);
   assign is_abs = opcode == OPW'(4) || opcode == OPW'(6);
   assign mask   = 4'(mm) & stat;
   // BNE/BNR (6,7) invert the sense of the flag test
   assign taken  = is_br && (opcode[1] ? mask == 4'd0 : mask != 4'd0);
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = 1'b0;
      case (state_q)
         START0:    state_d = START1;
         START1:    state_d = FETCH;
         FETCH:     state_d = DECODE;
         DECODE:    state_d = (opcode == OPW'(15)) ? HALT : EXECUTE;
         EXECUTE: begin
            state_d = is_alu ? WRITEBACK : (is_lod || is_str) ? MEM : FETCH;
            wait_d  = 8'd0;
         end
         MEM: begin
            if (mem_rdy) state_d = is_lod ? WRITEBACK : FETCH;
            else if (wait_q == 8'(MEM_WAIT_MAX - 1)) begin
               state_d = HALT;
               err_d   = 1'b1;
            end else wait_d = wait_q + 8'd1;
         end
         WRITEBACK: state_d = FETCH;
         default:   state_d = HALT;
      endcase
   end
   always_comb begin
      out_d = OUT_IDLE;
      case (state_d)
         FETCH:     out_d = 10'b1100_11_0000;
         EXECUTE:   out_d = {1'b0, taken, taken && is_abs, taken,
                             is_alu ? (mm == OPW'(IMM_MODE) ? 2'b01 : 2'b00) : (is_lod || is_str) ? 2'b10 : 2'b11,
                             4'b0000};
         MEM:       out_d = {4'b0000, 2'b11, 2'b00, is_lod, is_str};
         WRITEBACK: out_d = {4'b0000, 2'b11, 1'b1, is_lod, 2'b00};
         default:   out_d = OUT_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q   <= START1;
         wait_q    <= 8'd0;
         out_q     <= OUT_IDLE;
         halted_q  <= 1'b0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         out_q     <= out_d;
         halted_q  <= halted_q | (state_d == HALT);
         mem_err_q <= mem_err_q | err_d;
      end
   end
   assign {ir_load, pc_write, br_sel, pc_sel, alu_op, rf_we, wb_sel, mem_rd, mem_wr} = out_q;
   assign halted  = halted_q;
   assign mem_err = mem_err_q;
endmodule
